// File: rtl/button_debounce.sv
// Synchronises and debounces one active-low push-button pin into a clean level plus press/release strobes.
// Optional long-hold strobe is built only when LONG_PRESS_EN is defined; otherwise long_pulse is tied low.
module button_debounce #(
    parameter int unsigned CLK_HZ      = 27_000_000,
    parameter int unsigned DB_CYCLES   = 270_000,
    parameter int unsigned LONG_CYCLES = 27_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int unsigned DB_W = $clog2(DB_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    // Elaboration-time guard on parameter legality
    if (DB_CYCLES < 2 || LONG_CYCLES < 1 || CLK_HZ == 0) begin : g_bad_params
        $error("button_debounce: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t          state, state_d;
    logic [DB_W-1:0] db_cnt, db_cnt_d;
    logic            sync1, sync2;
    logic            pressed_d, press_pulse_d, release_pulse_d;

    // Two-flop synchroniser; idles at the released level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            db_cnt        <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_d;
            db_cnt        <= db_cnt_d;
            pressed       <= pressed_d;
            press_pulse   <= press_pulse_d;
            release_pulse <= release_pulse_d;
        end
    end

    // A level change is accepted only after DB_CYCLES consecutive agreeing samples
    always_comb begin
        state_d         = state;
        db_cnt_d        = db_cnt;
        pressed_d       = pressed;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        case (state)
            IDLE: begin
                if (!sync2) begin
                    state_d  = PRESS_WAIT;
                    db_cnt_d = DB_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (sync2) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_d       = PRESSED;
                    pressed_d     = 1'b1;
                    press_pulse_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt + DB_W'(1);
                end
            end
            PRESSED: begin
                if (sync2) begin
                    state_d  = RELEASE_WAIT;
                    db_cnt_d = DB_W'(1);
                end
            end
            RELEASE_WAIT: begin
                if (!sync2) begin
                    state_d  = PRESSED;
                    db_cnt_d = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_d         = IDLE;
                    db_cnt_d        = '0;
                    pressed_d       = 1'b0;
                    release_pulse_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt + DB_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                db_cnt_d = '0;
            end
        endcase
    end

`ifdef LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

    logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
    logic              long_pulse_d;
    logic              enter_pressed_c;

    assign enter_pressed_c = (state == PRESS_WAIT) && !sync2 && (db_cnt == DB_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt   <= '0;
            long_pulse <= 1'b0;
        end else begin
            hold_cnt   <= hold_cnt_d;
            long_pulse <= long_pulse_d;
        end
    end

    // Saturating hold counter: the LONG_CYCLES-1 match can occur only once per press
    always_comb begin
        hold_cnt_d   = hold_cnt;
        long_pulse_d = 1'b0;
        if (enter_pressed_c) begin
            hold_cnt_d = '0;
        end else if (state == PRESSED || state == RELEASE_WAIT) begin
            if (hold_cnt == HOLD_LAST) begin
                long_pulse_d = 1'b1;
            end
            if (hold_cnt != HOLD_MAX) begin
                hold_cnt_d = hold_cnt + HOLD_W'(1);
            end
        end
    end
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Randomised bench for button_debounce, checked against a run-length model of the debounce rules.
module tb_button_debounce;

    localparam int unsigned DB   = 8;
    localparam int unsigned LONG = 20;
`ifdef LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_n = 1'b0;
    logic pressed, press_pulse, release_pulse, long_pulse;

    int tests  = 0;
    int errors = 0;

    // Model: raw pin delayed two samples, level flips after DB opposing samples in a row
    bit m_s1, m_s2, m_level;
    int m_run, m_age;
    bit e_press, e_rel, e_long;

    always #5 clk = ~clk;

    button_debounce #(
        .CLK_HZ     (27_000_000),
        .DB_CYCLES  (DB),
        .LONG_CYCLES(LONG)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_n        (btn_n),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b0;
        m_run = 0; m_age = 0;
        e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
    endtask

    task automatic model_edge(input bit r, input bit b);
        bit want;
        if (r) begin
            model_reset();
            return;
        end
        e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
        want = !m_s2;
        if (m_level) begin
            m_age++;
            if (m_age == int'(LONG)) e_long = LONG_EN;
        end
        if (want != m_level) begin
            m_run++;
            if (m_run == int'(DB)) begin
                m_level = want;
                m_run   = 0;
                if (want) begin
                    e_press = 1'b1;
                    m_age   = 0;
                end else begin
                    e_rel = 1'b1;
                end
            end
        end else begin
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = b;
    endtask

    task automatic compare_all();
        check("pressed", 32'(pressed), 32'(m_level));
        check("press_pulse", 32'(press_pulse), 32'(e_press));
        check("release_pulse", 32'(release_pulse), 32'(e_rel));
        check("long_pulse", 32'(long_pulse), 32'(e_long));
        check("pulse_exclusive", 32'(press_pulse & release_pulse), 32'd0);
    endtask

    task automatic step(input bit r, input bit b);
        @(negedge clk);
        rst   = r;
        btn_n = b;
        @(posedge clk);
        model_edge(r, b);
        #1;
        compare_all();
    endtask

    // Reset raised between edges must clear outputs without waiting for a clock
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_pressed", 32'(pressed), 32'd0);
        check("async_rst_press_pulse", 32'(press_pulse), 32'd0);
        check("async_rst_release_pulse", 32'(release_pulse), 32'd0);
        check("async_rst_long_pulse", 32'(long_pulse), 32'd0);
        model_reset();
        step(1'b1, btn_n);
        step(1'b0, btn_n);
    endtask

    initial begin
        int lat;
        int n_press;
        model_reset();

        // Reset held with button down: everything stays low
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        lat = -1;
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b0);
            if (press_pulse && lat < 0) lat = i;
        end
        check("t1_press_latency", 32'(lat), 32'(DB + 1));

        // Release, then short presses that must be rejected
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1);
        n_press = 0;
        for (int k = 0; k < 10; k++) begin
            int len = int'($urandom_range(1, DB - 1));
            for (int i = 0; i < len; i++) begin
                step(1'b0, 1'b0);
                if (press_pulse) n_press++;
            end
            for (int i = 0; i < 3; i++) begin
                step(1'b0, 1'b1);
                if (press_pulse) n_press++;
            end
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0);
            if (press_pulse) n_press++;
        end
        check("t2_single_press", 32'(n_press), 32'd1);

        // Release bounces of 3 cycles while held, then a real release
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
            for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        end
        check("t3_still_pressed", 32'(pressed), 32'd1);
        lat = -1;
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b1);
            if (release_pulse && lat < 0) lat = i;
        end
        check("t3_release_latency", 32'(lat), 32'(DB + 1));

        // Long hold
        for (int i = 0; i < 50; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1);

        // Reset mid PRESS_WAIT (db_cnt=5) and mid PRESSED
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0);
        async_reset();
        for (int i = 0; i < 25; i++) step(1'b0, 1'b0);
        async_reset();
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1);

        // Random segments of stable and bouncy input
        for (int s = 0; s < 400; s++) begin
            int r = int'($urandom_range(0, 99));
            int lvl = int'($urandom_range(0, 1));
            int len = (r < 60) ? int'($urandom_range(1, DB + 2)) : int'($urandom_range(DB + 2, 45));
            if (r < 3) begin
                async_reset();
            end else begin
                for (int i = 0; i < len; i++) step(1'b0, lvl[0]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
